// File: rtl/sample_filter_bank.sv
// Sample-rate filter bank: moving-average FIR and first-order IIR run on every
// accepted sample; a runtime mode picks which result reaches the DAC path.
module sample_filter_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int FIR_DEPTH  = 8,
  parameter int IIR_FRAC   = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [1:0]            mode_i,
  input  logic [3:0]            shift_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  busy_o,
  output logic                  overrun_o
);
  localparam int LOG2   = $clog2(FIR_DEPTH);
  localparam int SUM_W  = DATA_WIDTH + LOG2;
  localparam int ACC_W  = DATA_WIDTH + IIR_FRAC + 1;
  localparam int DIFF_W = ACC_W + 1;

  typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;

  state_t                       state_q;
  logic signed [DATA_WIDTH-1:0] x_q, oldest_q, data_q;
  logic [1:0]                   m_q;
  logic [3:0]                   k_q;
  logic [LOG2-1:0]              wr_ptr_q;
  logic signed [DATA_WIDTH-1:0] ring_q [FIR_DEPTH];
  logic signed [SUM_W-1:0]      sum_q, sum_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic signed [DIFF_W-1:0]     diff, step, acc_sum;
  logic                         valid_q, overrun_q;

  function automatic logic signed [DATA_WIDTH-1:0] fir_mean(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] t;
    t = s >>> LOG2;
    return t[DATA_WIDTH-1:0];
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] iir_mean(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] t;
    t = a >>> IIR_FRAC;
    return t[DATA_WIDTH-1:0];
  endfunction

  // Filter next-state; the extra difference bit keeps full-scale steps exact at k=0.
  always_comb begin
    sum_d   = sum_q + SUM_W'(x_q) - SUM_W'(oldest_q);
    diff    = (DIFF_W'(x_q) <<< IIR_FRAC) - DIFF_W'(acc_q);
    step    = diff >>> k_q;
    acc_sum = DIFF_W'(acc_q) + step;
    acc_d   = acc_sum[ACC_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      sum_q     <= '0;
      acc_q     <= '0;
      wr_ptr_q  <= '0;
      for (int i = 0; i < FIR_DEPTH; i++) ring_q[i] <= '0;
    end else begin
      valid_q <= 1'b0;
      if (valid_i && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        IDLE: if (valid_i) begin
          x_q      <= data_i;
          m_q      <= mode_i;
          k_q      <= shift_i;
          oldest_q <= ring_q[wr_ptr_q];
          state_q  <= CALC;
        end
        CALC: begin
          sum_q            <= sum_d;
          acc_q            <= acc_d;
          ring_q[wr_ptr_q] <= x_q;
          wr_ptr_q         <= wr_ptr_q + LOG2'(1);
          state_q          <= EMIT;
        end
        EMIT: begin
          case (m_q)
            2'd1:    data_q <= x_q;
            2'd2:    data_q <= fir_mean(sum_q);
            2'd3:    data_q <= iir_mean(acc_q);
            default: data_q <= '0;
          endcase
          valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign busy_o    = (state_q != IDLE);
  assign overrun_o = overrun_q;
endmodule

// File: tb/tb_sample_filter_bank.sv
// Bench for sample_filter_bank: directed vector table, hand-written corner
// sequences, then random samples against an arithmetic reference model.
module tb_sample_filter_bank;
  logic               clk = 1'b0;
  logic               reset_i = 1'b1;
  logic               valid_i = 1'b0;
  logic signed [15:0] data_i = '0;
  logic [1:0]         mode_i = '0;
  logic [3:0]         shift_i = '0;
  logic signed [15:0] data_o;
  logic               valid_o, busy_o, overrun_o;

  int n_pass = 0;
  int n_total = 0;
  int vcount = 0;
  int vdata = 0;

  sample_filter_bank #(.DATA_WIDTH(16), .FIR_DEPTH(8), .IIR_FRAC(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .data_i(data_i),
    .mode_i(mode_i), .shift_i(shift_i), .data_o(data_o), .valid_o(valid_o),
    .busy_o(busy_o), .overrun_o(overrun_o)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (valid_o) begin
    vcount++;
    vdata = int'(data_o);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  // Reference model: last 8 samples kept in a queue, IIR as exact floor arithmetic.
  int     hist[$];
  longint macc;

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic void model_reset();
    hist.delete();
    repeat (8) hist.push_back(0);
    macc = 0;
  endfunction

  function automatic int model(input int x, input int m, input int k);
    longint s;
    s = 0;
    hist.push_back(x);
    void'(hist.pop_front());
    foreach (hist[i]) s += hist[i];
    macc = macc + fdiv(longint'(x) * 65536 - macc, longint'(1) << k);
    case (m)
      0:       return 0;
      1:       return x;
      2:       return int'(fdiv(s, 8));
      default: return int'(fdiv(macc, 65536));
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk); #1 reset_i = 1'b1; valid_i = 1'b0;
    @(negedge clk); #1 reset_i = 1'b0;
    model_reset();
  endtask

  task automatic run_sample(input int x, input int m, input int k, input int exp, input string name);
    int lat;
    @(negedge clk); #1;
    data_i = 16'(x); mode_i = 2'(m); shift_i = 4'(k); valid_i = 1'b1;
    @(negedge clk); #1 valid_i = 1'b0;
    check({name, "_busy"}, busy_o, 1);
    lat = 0;
    while (!valid_o && lat < 8) begin
      @(negedge clk); #1;
      lat++;
    end
    check({name, "_lat"}, lat, 2);
    check({name, "_data"}, data_o, exp);
  endtask

  typedef struct {
    bit rst;
    int x;
    int m;
    int k;
    int exp;
  } vec_t;
  vec_t vecs[$];

  initial begin
    vec_t v;
    v = '{1, -1234, 1, 0, -1234}; vecs.push_back(v);
    for (int i = 0; i < 10; i++) begin
      v = '{(i == 0), 800, 2, 0, (i < 8) ? 100 * (i + 1) : 800}; vecs.push_back(v);
    end
    for (int i = 0; i < 8; i++) begin
      v = '{(i == 0), -8, 2, 0, -(i + 1)}; vecs.push_back(v);
    end
    v = '{1, 1000, 3, 1, 500}; vecs.push_back(v);
    v = '{0, 1000, 3, 1, 750}; vecs.push_back(v);
    v = '{0, 1000, 3, 1, 875}; vecs.push_back(v);
    v = '{0, 1000, 3, 1, 937}; vecs.push_back(v);
    v = '{1, 1000, 3, 0, 1000}; vecs.push_back(v);
    for (int i = 0; i < 8; i++) begin
      v = '{(i == 0), 800, 0, 0, 0}; vecs.push_back(v);
    end
    v = '{0, 800, 2, 0, 800}; vecs.push_back(v);

    repeat (3) @(negedge clk);
    #1 reset_i = 1'b0;
    check("reset_data", data_o, 0);
    check("reset_valid", valid_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_overrun", overrun_o, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      run_sample(vecs[i].x, vecs[i].m, vecs[i].k, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Reset while the sample is in CALC discards it.
    do_reset();
    run_sample(-1234, 1, 0, -1234, "bypass_pre");
    @(negedge clk); #1 vcount = 0;
    data_i = 16'sd500; mode_i = 2'd1; valid_i = 1'b1;
    @(negedge clk); #1 valid_i = 1'b0; reset_i = 1'b1;
    @(negedge clk); #1 reset_i = 1'b0;
    check("midcalc_data", data_o, 0);
    check("midcalc_valid", valid_o, 0);
    check("midcalc_busy", busy_o, 0);
    check("midcalc_overrun", overrun_o, 0);
    repeat (5) @(negedge clk);
    check("midcalc_no_pulse", vcount, 0);
    model_reset();
    run_sample(800, 2, 0, 100, "fir_after_reset");

    // Second strobe one clock later is dropped and flagged.
    @(negedge clk); #1 vcount = 0;
    data_i = 16'sd100; mode_i = 2'd1; valid_i = 1'b1;
    @(negedge clk); #1 data_i = 16'sd555;
    @(negedge clk); #1 valid_i = 1'b0;
    repeat (6) @(negedge clk);
    check("overrun_pulses", vcount, 1);
    check("overrun_data", vdata, 100);
    check("overrun_flag", overrun_o, 1);
    run_sample(7, 1, 0, 7, "after_overrun");
    check("overrun_sticky", overrun_o, 1);
    do_reset();
    check("overrun_cleared", overrun_o, 0);

    // Strobes three clocks apart are both processed.
    @(negedge clk); #1 vcount = 0;
    data_i = 16'sd11; mode_i = 2'd1; valid_i = 1'b1;
    @(negedge clk); #1 valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk); #1 data_i = 16'sd22; valid_i = 1'b1;
    @(negedge clk); #1 valid_i = 1'b0;
    repeat (6) @(negedge clk);
    check("spacing3_pulses", vcount, 2);
    check("spacing3_data", vdata, 22);
    check("spacing3_overrun", overrun_o, 0);

    // Random samples against the reference model.
    do_reset();
    for (int i = 0; i < 150; i++) begin
      logic signed [15:0] rx;
      int m, k, e;
      rx = 16'($urandom);
      m  = int'($urandom_range(0, 3));
      k  = int'($urandom_range(0, 15));
      e  = model(int'(rx), m, k);
      run_sample(int'(rx), m, k, e, $sformatf("rand%0d", i));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check("rand_overrun", overrun_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
